// File: rtl/vdp_sprite_line_scanner.sv
// Per-line sprite attribute scanner: walks the 32-plane table and builds the visible-sprite list.
// Optional macro VDP_SPRITE_EXT_LIMIT_EN adds REG_EXT_LIMIT to raise the per-line limit to MAX_PER_LINE.
module vdp_sprite_line_scanner #(
  parameter int MAX_PER_LINE = 8,
  parameter int IDX_W        = 4
) (
  input  logic             CLK21M,
  input  logic             RESET,
  input  logic             START,
  input  logic [7:0]       LINE_Y,
  input  logic             SPMODE2,
  input  logic             REG_R1_SP_SIZE,
  input  logic             REG_R1_SP_ZOOM,
  input  logic             REG_R8_SP_OFF,
  input  logic [9:0]       REG_R11R5_SP_ATR_ADDR,
`ifdef VDP_SPRITE_EXT_LIMIT_EN
  input  logic             REG_EXT_LIMIT,
`endif
  output logic             ATR_REQ,
  output logic [16:0]      ATR_ADR,
  input  logic             ATR_ACK,
  input  logic [7:0]       ATR_DAT,
  output logic             BUSY,
  output logic             DONE,
  output logic [4:0]       LIST_COUNT,
  input  logic [IDX_W-1:0] LIST_RD_IDX,
  output logic [4:0]       LIST_RD_PLANE,
  output logic [3:0]       LIST_RD_YOFS,
  input  logic             S0_CLR,
  output logic             OVERMAPPED,
  output logic [4:0]       OVERMAPPED_NUM
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EVAL, S_FIN} state_t;

  localparam logic [4:0] MAX_L = 5'(MAX_PER_LINE);

  state_t     state_q, state_d;
  logic [4:0] plane_q, plane_d;
  logic [7:0] y_q, y_d;
  logic [4:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic [4:0] ovnum_q, ovnum_d;
  logic       list_we;

  logic [4:0] list_plane_q [MAX_PER_LINE];
  logic [3:0] list_yofs_q  [MAX_PER_LINE];

  logic [7:0] off;
  logic [5:0] height;
  logic       visible;
  logic       is_marker;
  logic [3:0] yofs_w;
  logic [4:0] base_limit;
  logic [4:0] limit;

  // Unsigned wrap makes sprites near Y=255 reach into the top lines.
  assign off       = LINE_Y - y_q - 8'd1;
  assign visible   = off < {2'b00, height};
  assign is_marker = SPMODE2 ? (y_q == 8'd216) : (y_q == 8'd208);
  assign yofs_w    = REG_R1_SP_ZOOM ? off[4:1] : off[3:0];
  assign base_limit = SPMODE2 ? 5'd8 : 5'd4;

`ifdef VDP_SPRITE_EXT_LIMIT_EN
  assign limit = REG_EXT_LIMIT ? MAX_L : ((base_limit > MAX_L) ? MAX_L : base_limit);
`else
  assign limit = (base_limit > MAX_L) ? MAX_L : base_limit;
`endif

  always_comb begin
    case ({REG_R1_SP_SIZE, REG_R1_SP_ZOOM})
      2'b00:   height = 6'd8;
      2'b11:   height = 6'd32;
      default: height = 6'd16;
    endcase
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      plane_q <= '0;
      y_q     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ovnum_q <= '0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      y_q     <= y_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ovnum_q <= ovnum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    y_d     = y_q;
    count_d = count_q;
    ovf_d   = S0_CLR ? 1'b0 : ovf_q;
    ovnum_d = ovnum_q;
    list_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          count_d = '0;
          if (REG_R8_SP_OFF) begin
            state_d = S_FIN;
          end else begin
            plane_d = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (ATR_ACK) begin
          y_d     = ATR_DAT;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (is_marker) begin
          state_d = S_FIN;
          if (!ovf_q) ovnum_d = plane_q;
        end else if (visible && (count_q == limit)) begin
          // Overflow set takes priority over a simultaneous status read clear.
          ovf_d   = 1'b1;
          state_d = S_FIN;
          if (!ovf_q) ovnum_d = plane_q;
        end else begin
          if (visible) begin
            list_we = 1'b1;
            count_d = count_q + 5'd1;
          end
          if (plane_q == 5'd31) begin
            state_d = S_FIN;
            if (!ovf_q) ovnum_d = plane_q;
          end else begin
            plane_d = plane_q + 5'd1;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ATR_REQ        = (state_q == S_REQ);
    ATR_ADR        = (state_q == S_REQ) ? {REG_R11R5_SP_ATR_ADDR, plane_q, 2'b00} : 17'd0;
    BUSY           = (state_q == S_REQ) || (state_q == S_EVAL);
    DONE           = (state_q == S_FIN);
    LIST_COUNT     = count_q;
    OVERMAPPED     = ovf_q;
    OVERMAPPED_NUM = ovnum_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PER_LINE; gi++) begin : g_entry
      always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
          list_plane_q[gi] <= '0;
          list_yofs_q[gi]  <= '0;
        end else if (list_we && (count_q == 5'(gi))) begin
          list_plane_q[gi] <= plane_q;
          list_yofs_q[gi]  <= yofs_w;
        end
      end
    end
  endgenerate

  // Entries past LIST_COUNT still hold the previous scan's data.
  always_comb begin
    LIST_RD_PLANE = '0;
    LIST_RD_YOFS  = '0;
    for (int i = 0; i < MAX_PER_LINE; i++) begin
      if (LIST_RD_IDX == IDX_W'(i)) begin
        LIST_RD_PLANE = list_plane_q[i];
        LIST_RD_YOFS  = list_yofs_q[i];
      end
    end
  end

endmodule

// File: doc/vdp_sprite_line_scanner.md
Name: vdp_sprite_line_scanner

Overview:
- Scans the 32-plane sprite attribute table once per display line.
- Selects the sprites that intersect the target line and stores each one's plane number and pattern row offset in a local list of MAX_PER_LINE entries.
- Raises the 5th/9th-sprite overflow status.
- Sits between the VRAM arbiter and the sprite pattern-fetch/draw stage; generalises the fixed 4/8-per-line evaluation to a parametrised list depth and size/zoom mode.

Parameters:
- MAX_PER_LINE, 8, list depth; legal range 8..16.
- IDX_W, 4, index width for the list read port; must satisfy 2**IDX_W >= MAX_PER_LINE.

Ports:
- CLK21M  in  1  system clock
- RESET  in  1  reset
- START  in  1  one-cycle pulse: begin scan for LINE_Y
- LINE_Y  in  8  target display line, already adjusted by R23
- SPMODE2  in  1  1 = sprite mode 2 (end marker 216, limit 8); 0 = mode 1 (end marker 208, limit 4)
- REG_R1_SP_SIZE  in  1  0 = 8x8, 1 = 16x16
- REG_R1_SP_ZOOM  in  1  1 = magnify x2
- REG_R8_SP_OFF  in  1  sprites disabled
- REG_R11R5_SP_ATR_ADDR  in  10  attribute table base, bits 16:7
- ATR_REQ  out  1  VRAM read request
- ATR_ADR  out  17  VRAM address
- ATR_ACK  in  1  ATR_DAT valid this cycle
- ATR_DAT  in  8  VRAM read data
- BUSY  out  1  scan in progress
- DONE  out  1  one-cycle pulse: list valid
- LIST_COUNT  out  5  number of valid entries
- LIST_RD_IDX  in  IDX_W  list read index
- LIST_RD_PLANE  out  5  plane number at index (combinational)
- LIST_RD_YOFS  out  4  pattern row at index (combinational)
- S0_CLR  in  1  status register 0 read: clear overflow flag
- OVERMAPPED  out  1  sticky overflow flag
- OVERMAPPED_NUM  out  5  overflow / last-scanned plane number

Behaviour:
- RESET is asynchronous, active-high; clock is CLK21M. Reset applies to all state.
- Reset values: state IDLE; ATR_REQ=0; ATR_ADR=0; BUSY=0; DONE=0; LIST_COUNT=0; OVERMAPPED=0; OVERMAPPED_NUM=0; list contents=0.
- States: IDLE, REQ, EVAL, FIN.
- IDLE:
  - START with SP_OFF=1 -> FIN; LIST_COUNT cleared to 0; no VRAM access.
  - START with SP_OFF=0 -> REQ; plane=0, LIST_COUNT=0.
- REQ:
  - ATR_REQ=1 with ATR_ADR={R11R5, plane[4:0], 2'b00}, held stable until ATR_ACK.
  - On ACK: capture ATR_DAT as Y, drop ATR_REQ next cycle, -> EVAL.
- EVAL (one cycle), in priority order:
  - Y==216 (mode 2) or Y==208 (mode 1) -> FIN (end marker).
  - off = (LINE_Y - Y - 1) mod 256, 8-bit. h = 8 << SIZE << ZOOM (8/16/32). Visible iff off < h.
  - Visible and LIST_COUNT == limit: set OVERMAPPED, load OVERMAPPED_NUM=plane -> FIN.
  - Visible otherwise: write entry[LIST_COUNT] = {plane, off>>ZOOM (low 4 bits)}, LIST_COUNT++.
  - Then plane==31 -> FIN; else plane++, -> REQ.
- Limit: mode 2 = 8, mode 1 = 4 (also capped at MAX_PER_LINE).
- Overflow number when no overflow: if a scan ends without overflow and OVERMAPPED=0, OVERMAPPED_NUM = last plane examined (marker plane, or 31).
- OVERMAPPED_NUM freeze: while OVERMAPPED=1, OVERMAPPED_NUM is not updated.
- FIN: DONE=1 for exactly one cycle, BUSY=0 -> IDLE.
- BUSY=1 in REQ and EVAL.
- START while BUSY is ignored.
- Scan latency: plane count x (ACK wait + 2) cycles, plus one cycle for FIN.
- List read during scan: the list read port returns the stale contents of the previous scan for indexes >= LIST_COUNT. Entries are valid after DONE until the next START.
- S0_CLR clears OVERMAPPED. If S0_CLR and an overflow set occur in the same cycle, set wins.
- RESET mid-scan returns to IDLE immediately; no DONE pulse is issued.

Optional Feature:
- Macro VDP_SPRITE_EXT_LIMIT_EN.
- Defined: adds input port REG_EXT_LIMIT (1 bit). When REG_EXT_LIMIT=1, the limit is MAX_PER_LINE in both modes and overflow triggers only at MAX_PER_LINE+1 visible sprites. When REG_EXT_LIMIT=0, behaviour is as without the macro.
- Undefined: no port; limit is fixed at 4/8.

Test Plan:
- Magnified large sprites, 5 visible:
  - Setup: mode 2, SIZE=1, ZOOM=1, base 0x1E00; Y=0 for planes 0..4; plane 5 Y=216; LINE_Y=10.
  - Expect: ATR_ADR 0x1E00, 0x1E04, ...; LIST_COUNT=5; YOFS 4 for each (off=9, >>1); DONE after plane 5; OVERMAPPED=0; OVERMAPPED_NUM=5.
- Mode 2 overflow:
  - Setup: 10 planes with Y=0, plane 10 Y=216, LINE_Y=1.
  - Expect: LIST_COUNT=8, OVERMAPPED=1, OVERMAPPED_NUM=8, no fetch of plane 9.
- Mode 1 limit and marker:
  - Setup: 6 visible sprites, plane 6 Y=208.
  - Expect: LIST_COUNT=4, OVERMAPPED_NUM=4. Repeat the scan with S0_CLR asserted on the overflow cycle: OVERMAPPED stays 1.
- Y wrap:
  - Setup: Y=250, SIZE=1, ZOOM=0, LINE_Y=5.
  - Expect: off=10, visible, YOFS=10. With Y=5, LINE_Y=5: off=255, not visible.
- Disable / busy / reset:
  - SP_OFF=1: DONE 1 cycle after START, LIST_COUNT=0, ATR_REQ never asserted.
  - START during BUSY: ignored.
  - RESET mid-REQ: ATR_REQ=0, BUSY=0, no DONE.
- VDP_SPRITE_EXT_LIMIT_EN:
  - Setup: MAX_PER_LINE=16, REG_EXT_LIMIT=1, 17 visible sprites.
  - Expect: LIST_COUNT=16, OVERMAPPED_NUM=16. With REG_EXT_LIMIT=0: LIST_COUNT=8.
